// File: rtl/ps2_kbd_rx.sv
// ---------------------------------------------------------------------------
// ps2_kbd_rx
//   PS/2 keyboard receiver. Synchronises and deglitches the PS/2 clock and data
//   lines in the clk_sys domain. It deframes 11-bit device->host frames (start,
//   8 data bits LSB-first, odd parity, stop). It reports each good byte and
//   decodes scan-code prefixes into key events. The host side only listens and
//   never drives the PS/2 lines.
//
// Ports
//   clk_sys       system clock, all logic on its rising edge
//   reset         synchronous, active-high
//   ps2_clk       PS/2 clock (asynchronous, idles high)
//   ps2_data      PS/2 data (asynchronous, idles high)
//   byte_strobe   1-cycle pulse, byte_data holds a freshly received byte
//   byte_data     last good byte, held until the next byte_strobe
//   key_strobe    1-cycle pulse, key_code/key_pressed/key_extended valid
//   key_code      scan code of the key event, prefixes stripped
//   key_pressed   1 = make, 0 = break (F0 prefix seen)
//   key_extended  1 = E0 prefix seen
//   err_parity    1-cycle pulse, frame dropped because of a parity error
//   err_frame     1-cycle pulse, frame dropped because of a bad start/stop bit
//                 or a timeout
// ---------------------------------------------------------------------------
module ps2_kbd_rx #(
  parameter int FILT_LEN = 4,
  parameter int TIMEOUT  = 2048
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_strobe,
  output logic [7:0] byte_data,
  output logic       key_strobe,
  output logic [7:0] key_code,
  output logic       key_pressed,
  output logic       key_extended,
  output logic       err_parity,
  output logic       err_frame
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  // Bytes that are neither prefixes nor key codes. They are protocol responses
  // from the keyboard, such as BAT ok, ack, resend, echo, pause lead-in and
  // overrun.
  function automatic logic is_non_key(input logic [7:0] b);
    case (b)
      8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'hE1, 8'h00, 8'hFF: is_non_key = 1'b1;
      default:                                        is_non_key = 1'b0;
    endcase
  endfunction

  logic [1:0]      clk_sync, data_sync;
  logic            clk_filt, data_filt;
  logic [3:0]      clk_fcnt, data_fcnt;
  logic            clk_filt_d;
  logic            fall, fall_data;
  logic [1:0]      state;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            acc, par_bit;
  logic            ext_flag, rel_flag;
  logic [TO_W-1:0] to_cnt;

  // Stage: two-flop synchronisers. Bit 1 is the safe, synchronised sample.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // Stage: level filters. The counter tracks how many consecutive samples have
  // disagreed with the filtered level. The level flips on the FILT_LEN-th one.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_filt  <= 1'b1;
      data_filt <= 1'b1;
      clk_fcnt  <= 4'd0;
      data_fcnt <= 4'd0;
    end else begin
      if (clk_sync[1] == clk_filt) begin
        clk_fcnt <= 4'd0;
      end else if (clk_fcnt == 4'(FILT_LEN - 1)) begin
        clk_filt <= clk_sync[1];
        clk_fcnt <= 4'd0;
      end else begin
        clk_fcnt <= clk_fcnt + 4'd1;
      end
      if (data_sync[1] == data_filt) begin
        data_fcnt <= 4'd0;
      end else if (data_fcnt == 4'(FILT_LEN - 1)) begin
        data_filt <= data_sync[1];
        data_fcnt <= 4'd0;
      end else begin
        data_fcnt <= data_fcnt + 4'd1;
      end
    end
  end

  // Stage: falling-edge detect. fall is high for exactly one cycle, the cycle
  // after the filtered clock drops. fall_data is the data bit sampled there.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_filt_d <= 1'b1;
      fall       <= 1'b0;
      fall_data  <= 1'b1;
    end else begin
      clk_filt_d <= clk_filt;
      fall       <= clk_filt_d & ~clk_filt;
      fall_data  <= data_filt;
    end
  end

  // Stage: frame FSM, prefix decode and registered outputs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state        <= ST_IDLE;
      bit_cnt      <= 3'd0;
      shreg        <= 8'h00;
      acc          <= 1'b0;
      par_bit      <= 1'b0;
      ext_flag     <= 1'b0;
      rel_flag     <= 1'b0;
      to_cnt       <= '0;
      byte_strobe  <= 1'b0;
      byte_data    <= 8'h00;
      key_strobe   <= 1'b0;
      key_code     <= 8'h00;
      key_pressed  <= 1'b0;
      key_extended <= 1'b0;
      err_parity   <= 1'b0;
      err_frame    <= 1'b0;
    end else begin
      byte_strobe <= 1'b0;
      key_strobe  <= 1'b0;
      err_parity  <= 1'b0;
      err_frame   <= 1'b0;

      // Saturating count of cycles since the last falling edge inside a frame.
      if (state == ST_IDLE || fall) begin
        to_cnt <= '0;
      end else if (to_cnt != TO_W'(TIMEOUT)) begin
        to_cnt <= to_cnt + TO_W'(1);
      end

      if (fall) begin
        case (state)
          ST_IDLE: begin
            if (!fall_data) begin
              state   <= ST_DATA;
              bit_cnt <= 3'd0;
              acc     <= 1'b0;
            end else begin
              err_frame <= 1'b1;
            end
          end
          ST_DATA: begin
            shreg   <= {fall_data, shreg[7:1]};
            acc     <= acc ^ fall_data;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par_bit <= fall_data;
            state   <= ST_STOP;
          end
          default: begin
            state <= ST_IDLE;
            if (!fall_data) begin
              err_frame <= 1'b1;
              ext_flag  <= 1'b0;
              rel_flag  <= 1'b0;
            end else if ((acc ^ par_bit) != 1'b1) begin
              err_parity <= 1'b1;
              ext_flag   <= 1'b0;
              rel_flag   <= 1'b0;
            end else begin
              byte_strobe <= 1'b1;
              byte_data   <= shreg;
              if (shreg == 8'hE0) begin
                ext_flag <= 1'b1;
              end else if (shreg == 8'hF0) begin
                rel_flag <= 1'b1;
              end else begin
                ext_flag <= 1'b0;
                rel_flag <= 1'b0;
                if (!is_non_key(shreg)) begin
                  key_strobe   <= 1'b1;
                  key_code     <= shreg;
                  key_pressed  <= ~rel_flag;
                  key_extended <= ext_flag;
                end
              end
            end
          end
        endcase
      end else if (state != ST_IDLE && to_cnt == TO_W'(TIMEOUT)) begin
        // An abandoned frame is dropped, but a pending prefix stays armed.
        state     <= ST_IDLE;
        err_frame <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// ---------------------------------------------------------------------------
// tb_ps2_kbd_rx
//   Self-checking bench for ps2_kbd_rx. A keyboard model drives PS/2 frames.
//   A reference model derives the expected bytes, key events and error counts
//   from the protocol rules. A monitor collects what the receiver reports.
// ---------------------------------------------------------------------------
module tb_ps2_kbd_rx;

  localparam int FILT_LEN = 4;
  localparam int TIMEOUT  = 2048;
  localparam int HALF     = 21;   // half of a 42-cycle PS/2 bit period

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic       byte_strobe;
  logic [7:0] byte_data;
  logic       key_strobe;
  logic [7:0] key_code;
  logic       key_pressed;
  logic       key_extended;
  logic       err_parity;
  logic       err_frame;

  ps2_kbd_rx #(.FILT_LEN(FILT_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .byte_strobe  (byte_strobe),
    .byte_data    (byte_data),
    .key_strobe   (key_strobe),
    .key_code     (key_code),
    .key_pressed  (key_pressed),
    .key_extended (key_extended),
    .err_parity   (err_parity),
    .err_frame    (err_frame)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc++;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor of the receiver outputs.
  logic [7:0] obs_bytes[$];
  logic [9:0] obs_keys[$];
  int         obs_perr = 0;
  int         obs_ferr = 0;
  int         obs_ferr_cyc = -1;
  int         pulse_viol = 0;

  always @(negedge clk_sys) begin
    if (byte_strobe) obs_bytes.push_back(byte_data);
    if (key_strobe)  obs_keys.push_back({key_extended, key_pressed, key_code});
    if (err_parity)  obs_perr++;
    if (err_frame) begin
      obs_ferr++;
      obs_ferr_cyc = cyc;
    end
    if ((int'(byte_strobe) + int'(err_parity) + int'(err_frame)) > 1 ||
        (key_strobe && !byte_strobe))
      pulse_viol++;
  end

  // Reference model: protocol rules applied frame by frame.
  logic [7:0] exp_bytes[$];
  logic [9:0] exp_keys[$];
  int         exp_perr = 0;
  int         exp_ferr = 0;
  bit         m_ext = 0;
  bit         m_rel = 0;

  task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    if (bad_stop) begin
      exp_ferr++;
      m_ext = 0; m_rel = 0;
    end else if (bad_par) begin
      exp_perr++;
      m_ext = 0; m_rel = 0;
    end else begin
      exp_bytes.push_back(b);
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_rel = 1;
      else begin
        if (!(b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'hE1, 8'h00, 8'hFF}))
          exp_keys.push_back({m_ext, ~m_rel, b});
        m_ext = 0; m_rel = 0;
      end
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  int last_fall_cyc = 0;

  // Keyboard model: sends the first nbits bits of a frame. glitch_bit >= 0
  // puts a short low glitch on ps2_clk during that bit's high phase.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits, input int glitch_bit);
    logic [10:0] bits;
    bits[0]   = 1'b0;
    bits[8:1] = b;
    bits[9]   = bad_par ? (^b) : ~(^b);
    bits[10]  = ~bad_stop;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      if (i == glitch_bit) begin
        wait_cyc(6);
        ps2_clk = 1'b0;
        wait_cyc(FILT_LEN - 1);
        ps2_clk = 1'b1;
        wait_cyc(HALF - 6 - (FILT_LEN - 1));
      end else begin
        wait_cyc(HALF);
      end
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 11, -1);
    model_frame(b, 1'b0, 1'b0);
  endtask

  task automatic verify(input string tag);
    int n;
    wait_cyc(FILT_LEN + 20);
    check_val({tag, "_nbytes"}, obs_bytes.size(), exp_bytes.size());
    n = (obs_bytes.size() < exp_bytes.size()) ? obs_bytes.size() : exp_bytes.size();
    for (int i = 0; i < n; i++) check_val({tag, "_byte"}, obs_bytes[i], exp_bytes[i]);
    check_val({tag, "_nkeys"}, obs_keys.size(), exp_keys.size());
    n = (obs_keys.size() < exp_keys.size()) ? obs_keys.size() : exp_keys.size();
    for (int i = 0; i < n; i++) check_val({tag, "_key"}, obs_keys[i], exp_keys[i]);
    check_val({tag, "_perr"}, obs_perr, exp_perr);
    check_val({tag, "_ferr"}, obs_ferr, exp_ferr);
    check_val({tag, "_pulse_mix"}, pulse_viol, 0);
    obs_bytes.delete(); exp_bytes.delete();
    obs_keys.delete();  exp_keys.delete();
    obs_perr = 0; obs_ferr = 0; exp_perr = 0; exp_ferr = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] pool[10];
    logic [7:0] b;
    int         r;
    bit         bp, bs;
    pool = '{8'hE0, 8'hF0, 8'hAA, 8'hFA, 8'h00, 8'hFF, 8'hE1, 8'hEE, 8'hFE, 8'h1C};

    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    wait_cyc(5);
    check_val("reset_byte_data", byte_data, 8'h00);
    check_val("reset_key_code", key_code, 8'h00);
    check_val("reset_flags", {key_pressed, key_extended, byte_strobe, key_strobe,
                              err_parity, err_frame}, 6'b0);
    reset = 1'b0;
    wait_cyc(10);
    obs_bytes.delete(); obs_keys.delete(); obs_perr = 0; obs_ferr = 0; pulse_viol = 0;

    // Single make code.
    send_good(8'h1C);
    verify("single_1c");

    // Extended break sequence.
    send_good(8'hE0);
    send_good(8'hF0);
    send_good(8'h75);
    verify("ext_break");

    // Parity error clears the pending break prefix.
    send_good(8'hF0);
    send_frame(8'h1C, 1'b1, 1'b0, 11, -1);
    model_frame(8'h1C, 1'b1, 1'b0);
    send_good(8'h1C);
    verify("parity_err");

    // Sub-threshold clock glitches in idle and mid-frame.
    wait_cyc(5);
    ps2_clk = 1'b0;
    wait_cyc(FILT_LEN - 1);
    ps2_clk = 1'b1;
    wait_cyc(30);
    send_frame(8'h5A, 1'b0, 1'b0, 11, 4);
    model_frame(8'h5A, 1'b0, 1'b0);
    verify("glitch");

    // Timeout on a partial frame keeps an armed E0 prefix.
    send_good(8'hE0);
    send_frame(8'h33, 1'b0, 1'b0, 5, -1);
    ps2_data = 1'b1;
    obs_ferr_cyc = -1;
    wait_cyc(TIMEOUT + FILT_LEN + 60);
    check_val("timeout_cycle", obs_ferr_cyc, last_fall_cyc + FILT_LEN + 4 + TIMEOUT + 1);
    exp_ferr++;
    send_good(8'h29);
    verify("timeout");

    // Reset in the middle of a frame drops it and clears a pending prefix.
    send_good(8'hF0);
    verify("pre_reset");
    send_frame(8'hA5, 1'b0, 1'b0, 5, -1);
    reset = 1'b1; ps2_data = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    m_ext = 0; m_rel = 0;
    wait_cyc(20);
    check_val("midreset_quiet", obs_bytes.size() + obs_keys.size() + obs_perr + obs_ferr, 0);
    send_good(8'h66);
    verify("mid_reset");

    // Randomised back-to-back traffic with occasional corrupted frames.
    for (int k = 0; k < 40; k++) begin
      r  = $urandom_range(0, 99);
      b  = (r < 40) ? pool[$urandom_range(0, 9)] : 8'($urandom);
      r  = $urandom_range(0, 9);
      bp = (r == 0);
      bs = (r == 1);
      send_frame(b, bp, bs, 11, -1);
      model_frame(b, bp, bs);
    end
    verify("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
